// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - splits 32-bit instruction words into big-endian byte writes
module inst_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddress,
  input  logic [CNT_W-1:0]  wordCount,
  input  logic              wordValid,
  input  logic [31:0]       wordData,
  output logic              wordReady,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [7:0]        memData,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] addrCnt;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        byteIdx;
  logic [31:0]       shiftReg;
  logic [31:0]       checksumReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = (wordCount == '0) ? DONE : ACCEPT;
      ACCEPT:  if (wordValid) nextState = WRITE;
      WRITE:   if (byteIdx == 2'd3) nextState = (remaining != '0) ? ACCEPT : DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Shift register drains to zero after four bytes, so memData idles at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      addrCnt     <= '0;
      remaining   <= '0;
      byteIdx     <= '0;
      shiftReg    <= '0;
      checksumReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addrCnt     <= baseAddress;
            remaining   <= wordCount;
            checksumReg <= '0;
          end
        end
        ACCEPT: begin
          if (wordValid) begin
            shiftReg    <= wordData;
            checksumReg <= checksumReg ^ wordData;
            remaining   <= remaining - CNT_W'(1);
            byteIdx     <= '0;
          end
        end
        WRITE: begin
          shiftReg <= {shiftReg[23:0], 8'h00};
          addrCnt  <= addrCnt + ADDR_W'(1);
          byteIdx  <= byteIdx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign wordReady  = (state == ACCEPT);
  assign memWrite   = (state == WRITE);
  assign memAddress = addrCnt;
  assign memData    = shiftReg[31:24];
  assign busy       = (state == ACCEPT) || (state == WRITE);
  assign done       = (state == DONE);
  assign checksum   = checksumReg;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - randomized self-checking bench for inst_mem_loader
module tb_inst_mem_loader;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] baseAddress;
  logic [CNT_W-1:0]  wordCount;
  logic              wordValid;
  logic [31:0]       wordData;
  logic              wordReady;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [7:0]        memData;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  inst_mem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .baseAddress(baseAddress),
    .wordCount(wordCount), .wordValid(wordValid), .wordData(wordData),
    .wordReady(wordReady), .memWrite(memWrite), .memAddress(memAddress),
    .memData(memData), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int readyInWrite = 0;
  logic [7:0]        memModel [256];
  logic [ADDR_W-1:0] obsAddr [$];
  logic [7:0]        obsData [$];

  // Byte-addressed instruction memory model fed by the write port.
  always @(negedge clk) begin
    if (memWrite === 1'b1) begin
      obsAddr.push_back(memAddress);
      obsData.push_back(memData);
      memModel[memAddress] = memData;
    end
    if (memWrite === 1'b1 && wordReady === 1'b1) readyInWrite++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] readWord(input logic [7:0] a);
    return {memModel[a], memModel[8'(a + 8'd1)], memModel[8'(a + 8'd2)], memModel[8'(a + 8'd3)]};
  endfunction

  task automatic startLoad(input logic [7:0] base, input int n);
    obsAddr.delete();
    obsData.delete();
    start       = 1'b1;
    baseAddress = base;
    wordCount   = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] w, input int prob, input bit spam);
    bit accepted = 1'b0;
    int guard = 0;
    wordData = w;
    while (!accepted && guard < 200) begin
      wordValid = ($urandom_range(0, 99) < prob);
      if (spam) begin
        start       = 1'b1;
        baseAddress = ADDR_W'($urandom);
        wordCount   = CNT_W'($urandom);
      end
      accepted = wordValid && wordReady;
      @(posedge clk); #1;
      guard++;
    end
    wordValid = 1'b0;
    if (!accepted) checkVal("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone(input logic [31:0] expSum, input int expLat, input bit spam);
    int lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (spam) start = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checkVal("done_latency", lat, expLat);
    checkVal("checksum", checksum, expSum);
    checkVal("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    checkVal("done_pulse_width", {31'd0, done}, 32'd0);
    checkVal("checksum_hold", checksum, expSum);
  endtask

  task automatic runLoad(input logic [7:0] base, input logic [31:0] words[$], input int prob, input bit spam);
    logic [31:0] sum = 32'd0;
    int nBytes;
    startLoad(base, words.size());
    if (words.size() > 0) checkVal("ready_after_start", {31'd0, wordReady}, 32'd1);
    foreach (words[i]) begin
      pushWord(words[i], prob, spam);
      sum ^= words[i];
    end
    waitDone(sum, (words.size() == 0) ? 0 : 4, spam);
    repeat (4) @(posedge clk);
    #1;
    nBytes = 4 * words.size();
    checkVal("write_count", obsAddr.size(), nBytes);
    for (int i = 0; i < nBytes && i < obsAddr.size(); i++) begin
      logic [7:0]  ea = base + 8'(i);
      logic [31:0] w  = words[i / 4];
      logic [7:0]  ed = 8'(w >> (24 - 8 * (i % 4)));
      checkVal($sformatf("wr_addr[%0d]", i), {24'd0, obsAddr[i]}, {24'd0, ea});
      checkVal($sformatf("wr_data[%0d]", i), {24'd0, obsData[i]}, {24'd0, ed});
    end
    foreach (words[i])
      checkVal($sformatf("readback[%0d]", i), readWord(base + 8'(4 * i)), words[i]);
    checkVal("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] w1;
    logic [31:0] w2;
    logic [7:0]  prior;

    reset = 1'b1; start = 1'b0; baseAddress = '0; wordCount = '0;
    wordValid = 1'b0; wordData = '0;
    for (int i = 0; i < 256; i++) memModel[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_memAddress", {24'd0, memAddress}, 32'd0);
    checkVal("rst_memData", {24'd0, memData}, 32'd0);
    checkVal("rst_checksum", checksum, 32'd0);
    checkVal("rst_flags", {28'd0, wordReady, memWrite, busy, done}, 32'd0);

    reset = 1'b0;
    wordValid = 1'b1;
    wordData = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      checkVal("idle_flags", {28'd0, wordReady, memWrite, busy, done}, 32'd0);
      @(posedge clk); #1;
    end
    wordValid = 1'b0;

    q.delete(); q.push_back(32'h12345678);
    runLoad(8'h00, q, 100, 1'b0);
    checkVal("single_word_sum", checksum, 32'h12345678);

    q.delete(); q.push_back(32'hAABBCCDD); q.push_back(32'h01020304);
    runLoad(8'hFE, q, 100, 1'b0);

    q.delete();
    for (int i = 0; i < 64; i++) q.push_back($urandom);
    runLoad(8'($urandom), q, 50, 1'b0);
    checkVal("ready_during_write", readyInWrite, 32'd0);

    q.delete();
    runLoad(8'h80, q, 100, 1'b0);

    q.delete();
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    runLoad(8'h20, q, 60, 1'b1);

    w1 = $urandom;
    w2 = $urandom;
    prior = memModel[8'h47];
    startLoad(8'h40, 3);
    pushWord(w1, 100, 1'b0);
    pushWord(w2, 100, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkVal("third_byte_addr", {24'd0, memAddress}, 32'h46);
    reset = 1'b1;
    @(posedge clk); #1;
    checkVal("abort_flags", {28'd0, wordReady, memWrite, busy, done}, 32'd0);
    checkVal("abort_memAddress", {24'd0, memAddress}, 32'd0);
    checkVal("abort_checksum", checksum, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkVal("abort_writes", obsAddr.size(), 32'd7);
    checkVal("partial_word", readWord(8'h44), {w2[31:8], prior});

    q.delete(); q.push_back($urandom); q.push_back($urandom);
    runLoad(8'h40, q, 70, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
